// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Optional OVF signal present when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock through a single borrow flop.
// Define SERIAL_SUB_OVF_EN to add the two's-complement OVF output.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ov_q, ov_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             a_i, b_i;
  logic             d_bit;
  logic             brw_nx;
  logic [WIDTH-1:0] res_nx;

  assign a_i    = a_q[0];
  assign b_i    = b_q[0];
  assign d_bit  = a_i ^ b_i ^ brw_q;
  assign brw_nx = (~a_i & b_i) | (~a_i & brw_q) | (b_i & brw_q);
  assign res_nx = {d_bit, res_q[WIDTH-1:1]};

  // Next-state and datapath: latch, shift one bit, publish, hand off
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ov_d    = ov_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          brw_d   = bus.bin;
          cnt_d   = '0;
          ov_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_nx;
        brw_d = brw_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = res_nx;
          bout_d  = brw_nx;
          ov_d    = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = brw_q ^ brw_nx;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ov_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ov_q    <= ov_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor.
// Reference is plain unsigned/signed arithmetic on the operands.
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout sim did not finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_diff(input int a, b, bin);
    int r;
    r = a - b - bin;
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic m_bout(input int a, b, bin);
    return (a < b + bin);
  endfunction

  function automatic logic m_ovf(input int a, b, bin);
    int sa, sb, r;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb - bin;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input int a, b, bin, hold, noise);
    logic [W-1:0] ed;
    logic         eb;
    ed = m_diff(a, b, bin);
    eb = m_bout(a, b, bin);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_idle();
    bus.a        = W'(a);
    bus.b        = W'(b);
    bus.bin      = 1'(bin);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'(noise);
    if (noise != 0) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.bin = 1'($urandom);
    end
    for (int k = 0; k < W; k++) begin
      check("lat_ov", 32'(bus.out_valid), 32'd0);
      check("lat_rdy", 32'(bus.in_ready), 32'd0);
      check("lat_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    check("done_ov", 32'(bus.out_valid), 32'd1);
    check("diff", 32'(bus.diff), 32'(ed));
    check("bout", 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(bus.ovf), 32'(m_ovf(a, b, bin)));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ov", 32'(bus.out_valid), 32'd1);
      check("hold_diff", 32'(bus.diff), 32'(ed));
      check("hold_bout", 32'(bus.bout), 32'(eb));
      check("hold_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("rel_ov", 32'(bus.out_valid), 32'd0);
    check("rel_rdy", 32'(bus.in_ready), 32'd1);
    check("rel_diff", 32'(bus.diff), 32'(ed));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int acc_t[2];
    int n_acc;
    int n_res;
    logic [W-1:0] e2d[2];
    logic         e2b[2];

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(9, 3, 0, 0, 0);
    run_op(3, 9, 0, 0, 0);
    run_op(0, 0, 1, 0, 0);
    run_op(15, 15, 0, 0, 0);
    run_op(13, 4, 1, 5, 1);

    // reset in the middle of SHIFT
    wait_idle();
    bus.a        = W'(11);
    bus.b        = W'(1);
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_diff", 32'(bus.diff), 32'(m_diff(13, 4, 1)));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_bout", 32'(bus.bout), 32'd0);
    check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(5, 2, 0, 0, 0);

    // back-to-back with IN_VALID high and OUT_READY tied high
    e2d[0] = m_diff(12, 5, 0);
    e2b[0] = m_bout(12, 5, 0);
    e2d[1] = m_diff(2, 7, 0);
    e2b[1] = m_bout(2, 7, 0);
    n_acc  = 0;
    n_res  = 0;
    acc_t  = '{0, 0};
    bus.a         = W'(12);
    bus.b         = W'(5);
    bus.bin       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && n_res < 2; i++) begin
      if (bus.out_valid) begin
        check("b2b_diff", 32'(bus.diff), 32'(e2d[n_res]));
        check("b2b_bout", 32'(bus.bout), 32'(e2b[n_res]));
        n_res++;
      end
      if (n_acc == 1 && !bus.in_ready) begin
        bus.a = W'(2);
        bus.b = W'(7);
      end
      if (n_acc == 2 && !bus.in_ready) bus.in_valid = 1'b0;
      if (bus.in_ready && bus.in_valid && n_acc < 2) begin
        acc_t[n_acc] = i;
        n_acc++;
      end
      @(negedge clk);
    end
    check("b2b_nres", 32'(n_res), 32'd2);
    check("b2b_gap", 32'(acc_t[1] - acc_t[0]), 32'(W + 2));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8, 1, 0, 0, 0);
    run_op(7, 8, 0, 0, 0);
    run_op(6, 2, 0, 0, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      run_op(int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, (1 << W) - 1)),
             int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtractor: the inverse arithmetic partner of the team's parallel ripple-carry adder. It accepts two WIDTH-bit operands and a borrow-in over a valid/ready handshake, and resolves one bit per clock through a single borrow flip-flop. It presents DIFF/BOUT over an output valid/ready handshake. It is used where area matters more than latency, and as a sequential fault-simulation test design.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  reset; asynchronous assert, active-low
IN_VALID  input  1  operands valid
IN_READY  output  1  block can accept operands
A  input  WIDTH  minuend, unsigned
B  input  WIDTH  subtrahend, unsigned
BIN  input  1  borrow-in
OUT_VALID  output  1  DIFF/BOUT valid
OUT_READY  input  1  consumer accepts result
DIFF  output  WIDTH  (A - B - BIN) mod 2^WIDTH
BOUT  output  1  borrow-out; 1 iff A < B + BIN (unsigned)
BUSY  output  1  high in SHIFT and DONE

Behaviour:
- States: IDLE, SHIFT, DONE. The counter width is ceil(log2(WIDTH)).
- Reset (RST_N low, asynchronous):
  - State goes to IDLE.
  - OUT_VALID=0, DIFF=0, BOUT=0, BUSY=0, and the internal borrow, counter and operand registers are cleared.
  - IN_READY=1, because it is decoded from the IDLE state. Inputs are ignored while RST_N is low.
- IN_READY = (state==IDLE); it is combinational from state only and does not depend on IN_VALID.
- IDLE: on IN_VALID & IN_READY, latch A and B into shift registers, load borrow=BIN and cnt=0, clear OUT_VALID, then go to SHIFT. DIFF and BOUT keep their previous result until overwritten.
- SHIFT, each cycle, for bit i = cnt (LSB first):
  - d = a_i ^ b_i ^ borrow
  - borrow_next = (~a_i & b_i) | (~a_i & borrow) | (b_i & borrow)
  - d shifts into the MSB of the result register, which shifts right; cnt increments.
  - On the cycle where cnt==WIDTH-1, go to DONE: the result register is copied to DIFF, borrow_next goes to BOUT, and OUT_VALID is set to 1.
- Latency: if the accept edge is edge k, OUT_VALID is high after edge k+WIDTH. The block is never interrupted by IN_VALID.
- DONE:
  - DIFF, BOUT and OUT_VALID are held stable for as long as OUT_READY=0.
  - On OUT_VALID & OUT_READY, clear OUT_VALID and go to IDLE.
  - No new operand is accepted in the same cycle; IN_READY rises on the following cycle. Minimum throughput is one operation per WIDTH+2 cycles.
- IN_VALID held high in SHIFT or DONE: no effect. Operands are sampled only at the accept edge.
- Reset mid-SHIFT or mid-DONE: the partial result is discarded and all outputs take their reset values immediately.
- Wrap-around: the result is modulo 2^WIDTH. BOUT carries the lost borrow, e.g. 0 - 0 - 1 gives DIFF = all ones, BOUT=1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: an extra port OVF (output, 1 bit) signals two's-complement overflow. It is computed as the borrow into the MSB XOR the borrow out of the MSB, and is registered together with DIFF. It resets to 0, is held in DONE, and is valid only while OUT_VALID=1.
- Undefined: the OVF port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=4, A=9, B=3, BIN=0 -> DIFF=6, BOUT=0; OUT_VALID rises exactly 4 edges after the accept edge; IN_READY=0 and BUSY=1 in between.
2. A=3, B=9, BIN=0 -> DIFF=0xA, BOUT=1. Then A=0, B=0, BIN=1 -> DIFF=0xF, BOUT=1. Then A=15, B=15, BIN=0 -> DIFF=0, BOUT=0.
3. Backpressure: hold OUT_READY=0 for 5 cycles in DONE while driving IN_VALID=1 with A=1, B=1 -> DIFF/BOUT stay unchanged, IN_READY=0, and the new operand is not taken. Releasing OUT_READY causes OUT_VALID to fall after one edge and IN_READY to rise.
4. Reset mid-operation: drop RST_N after 2 SHIFT cycles -> OUT_VALID=0, DIFF=0, BOUT=0 immediately (asynchronously). After release, IN_READY=1, and A=5, B=2, BIN=0 -> DIFF=3, BOUT=0.
5. Back-to-back: two operations with IN_VALID held high and OUT_READY tied to 1 -> accept edges are 6 cycles apart and both results are correct (12-5 gives 7; 2-7 gives 0xB with BOUT=1).
6. With SERIAL_SUB_OVF_EN defined: A=8, B=1 -> DIFF=7, OVF=1. A=7, B=8 -> DIFF=0xF, OVF=1, BOUT=1. A=6, B=2 -> DIFF=4, OVF=0.
